// File: rtl/emit_cnt_resp.sv
// Responder end of the dispense-count handshake: holds the pour-unit down-counter,
// opens the valve for TICK_CYC clocks per count request and acknowledges four-phase.
module emit_cnt_resp #(
  parameter int WIDTH    = 8,
  parameter int TICK_CYC = 1000,
  parameter int PW       = 10
) (
  input  logic             clk,
  input  logic             RESET,
  input  logic [WIDTH-1:0] load_val,
  input  logic             cnt_ld,
  input  logic             ld_lock,
  input  logic             cnt_clr,
  input  logic             count_req,
  output logic             count_ack,
  output logic             eq_0,
  output logic [WIDTH-1:0] cnt_val,
  output logic             valve_on,
  output logic             emit_done,
  output logic             underflow
);

  typedef enum logic [1:0] {IDLE, RUN, ACK} state_t;

  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_CYC - 1);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] cnt_reg, cnt_next;
  logic [PW-1:0]    pre_reg, pre_next;
  logic             emit_done_reg, emit_done_next;
  logic             underflow_reg, underflow_next;
  logic             tick_last;
  logic             cnt_zero;

  assign cnt_zero  = (cnt_reg == '0);
  assign tick_last = (state_reg == RUN) && (pre_reg == PRE_LAST);

  // State register
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; a clear aborts from any state without acknowledging
  always_comb begin
    state_next = state_reg;
    if (cnt_clr) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (count_req) begin
            state_next = cnt_zero ? ACK : RUN;
          end
        end
        RUN: begin
          if (tick_last) begin
            state_next = ACK;
          end
        end
        ACK: begin
          if (!count_req) begin
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Moore outputs
  always_comb begin
    count_ack = 1'b0;
    valve_on  = 1'b0;
    case (state_reg)
      RUN:     valve_on  = 1'b1;
      ACK:     count_ack = 1'b1;
      default: ;
    endcase
  end

  // Datapath next values: clear beats load beats decrement
  always_comb begin
    cnt_next       = cnt_reg;
    pre_next       = pre_reg;
    emit_done_next = 1'b0;
    underflow_next = underflow_reg;
    if (cnt_clr) begin
      cnt_next       = '0;
      underflow_next = 1'b0;
    end else begin
      if (state_reg == IDLE && count_req) begin
        if (cnt_zero) begin
          underflow_next = 1'b1;
        end else begin
          pre_next = '0;
        end
      end
      if (state_reg == RUN) begin
        pre_next = pre_reg + PW'(1);
      end
      if (cnt_ld && !ld_lock && state_reg == IDLE) begin
        cnt_next = load_val;
        if (!(count_req && cnt_zero)) begin
          underflow_next = 1'b0;
        end
      end else if (tick_last) begin
        // RUN is only entered with a nonzero count, so this never wraps
        cnt_next       = cnt_reg - WIDTH'(1);
        emit_done_next = (cnt_reg == WIDTH'(1));
      end
    end
  end

  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      cnt_reg       <= '0;
      pre_reg       <= '0;
      emit_done_reg <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      cnt_reg       <= cnt_next;
      pre_reg       <= pre_next;
      emit_done_reg <= emit_done_next;
      underflow_reg <= underflow_next;
    end
  end

  assign eq_0      = cnt_zero;
  assign cnt_val   = cnt_reg;
  assign emit_done = emit_done_reg;
  assign underflow = underflow_reg;

endmodule

// File: tb/tb_emit_cnt_resp.sv
// Directed bench for emit_cnt_resp with TICK_CYC=4: table of per-cycle vectors
// plus hand-written async-reset and full-count sequences.
module tb_emit_cnt_resp;

  localparam int WIDTH = 8;
  localparam int TICK  = 4;

  logic             clk = 1'b0;
  logic             RESET;
  logic [WIDTH-1:0] load_val;
  logic             cnt_ld, ld_lock, cnt_clr, count_req;
  logic             count_ack, eq_0, valve_on, emit_done, underflow;
  logic [WIDTH-1:0] cnt_val;

  int checks   = 0;
  int failures = 0;

  emit_cnt_resp #(.WIDTH(WIDTH), .TICK_CYC(TICK), .PW(3)) dut (
    .clk(clk), .RESET(RESET), .load_val(load_val), .cnt_ld(cnt_ld),
    .ld_lock(ld_lock), .cnt_clr(cnt_clr), .count_req(count_req),
    .count_ack(count_ack), .eq_0(eq_0), .cnt_val(cnt_val),
    .valve_on(valve_on), .emit_done(emit_done), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       ld, lock, clr, req;
    logic [7:0] val;
    logic [7:0] e_cnt;
    logic       e_ack, e_valve, e_eq0, e_done, e_uf;
  } vec_t;

  vec_t vecs[$];

  task automatic add(string name, logic ld, logic lock, logic clr, logic req, logic [7:0] val,
                     logic [7:0] e_cnt, logic e_ack, logic e_valve, logic e_eq0,
                     logic e_done, logic e_uf);
    vec_t v;
    v.name = name; v.ld = ld; v.lock = lock; v.clr = clr; v.req = req; v.val = val;
    v.e_cnt = e_cnt; v.e_ack = e_ack; v.e_valve = e_valve; v.e_eq0 = e_eq0;
    v.e_done = e_done; v.e_uf = e_uf;
    vecs.push_back(v);
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  function automatic logic [12:0] outs();
    return {cnt_val, count_ack, valve_on, eq_0, emit_done, underflow};
  endfunction

  initial begin
    int vc, dc, acked;
    logic [12:0] exp_o;

    RESET = 1'b0; load_val = '0; cnt_ld = 0; ld_lock = 0; cnt_clr = 0; count_req = 0;
    #2;
    chk("reset_outputs", {19'd0, outs()}, {19'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
    @(negedge clk); RESET = 1'b1;

    //   name        ld lk cl rq val  cnt ack vlv eq0 dn uf
    add("t1_load3",   1, 0, 0, 0, 3,   3, 0, 0, 0, 0, 0);
    add("t1_req1",    0, 0, 0, 1, 0,   3, 0, 1, 0, 0, 0);
    add("t1_run1b",   0, 0, 0, 1, 0,   3, 0, 1, 0, 0, 0);
    add("t1_run1c",   0, 0, 0, 1, 0,   3, 0, 1, 0, 0, 0);
    add("t1_run1d",   0, 0, 0, 1, 0,   3, 0, 1, 0, 0, 0);
    add("t1_ack1",    0, 0, 0, 1, 0,   2, 1, 0, 0, 0, 0);
    add("t2_ackhold", 1, 1, 0, 1, 9,   2, 1, 0, 0, 0, 0);
    add("t2_drop",    1, 1, 0, 0, 9,   2, 0, 0, 0, 0, 0);
    add("t2_locked",  1, 1, 0, 0, 9,   2, 0, 0, 0, 0, 0);
    add("t1_req2",    0, 0, 0, 1, 0,   2, 0, 1, 0, 0, 0);
    add("t1_run2b",   0, 0, 0, 1, 0,   2, 0, 1, 0, 0, 0);
    add("t1_run2c",   0, 0, 0, 1, 0,   2, 0, 1, 0, 0, 0);
    add("t1_run2d",   0, 0, 0, 1, 0,   2, 0, 1, 0, 0, 0);
    add("t1_ack2",    0, 0, 0, 1, 0,   1, 1, 0, 0, 0, 0);
    add("t1_drop2",   0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0);
    add("t1_req3",    0, 0, 0, 1, 0,   1, 0, 1, 0, 0, 0);
    add("t1_run3b",   0, 0, 0, 1, 0,   1, 0, 1, 0, 0, 0);
    add("t1_run3c",   0, 0, 0, 1, 0,   1, 0, 1, 0, 0, 0);
    add("t1_run3d",   0, 0, 0, 1, 0,   1, 0, 1, 0, 0, 0);
    add("t1_ack3",    0, 0, 0, 1, 0,   0, 1, 0, 1, 1, 0);
    add("t1_drop3",   0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0);
    add("t3_req0",    0, 0, 0, 1, 0,   0, 1, 0, 1, 0, 1);
    add("t3_drop",    0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 1);
    add("t3_load5",   1, 0, 0, 0, 5,   5, 0, 0, 0, 0, 0);
    add("t6_clr_ld",  1, 0, 1, 0, 7,   0, 0, 0, 1, 0, 0);
    add("t4_load2",   1, 0, 0, 0, 2,   2, 0, 0, 0, 0, 0);
    add("t4_req",     0, 0, 0, 1, 0,   2, 0, 1, 0, 0, 0);
    add("t4_clr_run", 0, 0, 1, 1, 0,   0, 0, 0, 1, 0, 0);
    add("t4_idle",    0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      cnt_ld = vecs[i].ld; ld_lock = vecs[i].lock; cnt_clr = vecs[i].clr;
      count_req = vecs[i].req; load_val = vecs[i].val;
      @(posedge clk); #1;
      exp_o = {vecs[i].e_cnt, vecs[i].e_ack, vecs[i].e_valve, vecs[i].e_eq0,
               vecs[i].e_done, vecs[i].e_uf};
      chk(vecs[i].name, {19'd0, outs()}, {19'd0, exp_o});
    end

    // T5: asynchronous reset in the middle of RUN
    @(negedge clk); cnt_ld = 1; load_val = 8'd3; cnt_clr = 0; count_req = 0;
    @(negedge clk); cnt_ld = 0; count_req = 1;
    @(negedge clk);
    @(negedge clk);
    chk("t5_valve_before_reset", {31'd0, valve_on}, 32'd1);
    #1 RESET = 1'b0;
    #1;
    chk("t5_async_reset", {19'd0, outs()}, {19'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
    count_req = 0;
    @(negedge clk); RESET = 1'b1;

    // Single-unit pour with bounded wait for the acknowledge
    @(negedge clk); cnt_ld = 1; load_val = 8'd1;
    @(negedge clk); cnt_ld = 0; count_req = 1;
    vc = 0; dc = 0; acked = 0;
    for (int i = 0; i < 20 && acked == 0; i++) begin
      @(negedge clk);
      if (valve_on) vc++;
      if (emit_done) dc++;
      if (count_ack) acked = 1;
    end
    chk("pour1_ack_seen", acked, 1);
    chk("pour1_valve_cycles", vc, TICK);
    chk("pour1_emit_done", dc, 1);
    chk("pour1_cnt", {24'd0, cnt_val}, 32'd0);
    count_req = 0;
    @(negedge clk);
    chk("pour1_ack_release", {31'd0, count_ack}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
